mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter that shares the 7-to-1 bit multiplexer between seven requesters. It grants the mux to one requester at a time and drives the mux's 3-bit select with the granted index. It holds each grant until the owner releases it, and rotates priority so that no requester starves. It sits directly in front of the mux's select input; the mux data path is unchanged.

## Interface
Parameters:
- `N_REQ`, 7: number of requesters. Fixed to the mux width; other values are unsupported.
- `HOLD_MAX`, 15: maximum cycles one grant may be held while others wait. Only used with `HOLD_LIMIT_EN`. Must be ≥1.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  7  request vector; `req[i]` high means requester i wants the mux.
- `grant`  out  7  one-hot grant vector; all zero when idle.
- `grant_valid`  out  1  high while any grant is held.
- `mux_select`  out  3  index of the granted requester; connects to the mux select.

## Operation
- Two states: `IDLE` and `GRANT`.
- Search order: the pick starts at `ptr` and scans upward mod 7. The first asserted `req` wins.
- `ptr` is a 3-bit rotation pointer, range 0..6. It wraps from 6 to 0 and never holds 7.
- **IDLE:**
  - If any `req` is high at an edge, go to `GRANT` and register `grant`, `mux_select` and `grant_valid=1` for the picked index.
  - Otherwise stay in `IDLE`.
- **GRANT, owner g:**
  - While `req[g]=1`, hold all outputs.
  - When `req[g]=0` at an edge:
    - set `ptr` to (g+1) mod 7;
    - pick again from the new `ptr` in the same edge (g is excluded because its request is low);
    - if a winner exists, stay in `GRANT` with the new owner (back-to-back, no idle cycle);
    - else go to `IDLE`.
- **Leaving GRANT for IDLE:**
  - `grant` and `grant_valid` are cleared.
  - `mux_select` holds its last value, so the mux output stays stable.
- **Reset value of every output:**
  - `grant` = 0
  - `grant_valid` = 0
  - `mux_select` = 3'b000
  - `ptr` = 0
  - state = `IDLE`
  - hold counter = 0
- **Reset mid-grant:** outputs clear immediately and asynchronously. The first pick after reset starts from index 0.
- **Simultaneous release and new request:** both are seen at the same edge. The new requester is eligible if it lies in the search order.
- Requesters 7 and above do not exist. `mux_select` never drives 3'b111.

## Timing
- Request-to-grant latency is 1 cycle. A `req[i]` sampled high at edge k in `IDLE` gives `grant[i]` valid after edge k.
- Release-to-regrant latency is 1 cycle. A `req[g]` sampled low at edge k moves the grant to the next owner after edge k.
- All outputs are registered; there is no combinational path from `req` to the outputs.
- `grant` is one-hot or zero in every cycle.

## Configuration
- Macro: `HOLD_LIMIT_EN`.
- **Defined:**
  - A hold counter, width $clog2(`HOLD_MAX`+1), counts cycles in `GRANT` and resets to 0 on every new grant.
  - When the counter equals `HOLD_MAX` and some other `req[j]` (j≠g) is high, the grant is preempted at that edge.
  - Preemption moves `ptr` to g+1 and re-picks exactly as a release does.
  - If no other requester is waiting, the counter saturates and the grant continues.
- **Undefined:**
  - No counter is built.
  - A grant lasts until the owner deasserts `req`.

## Structure
- Package `mux_arb_pkg` holds:
  - `N_REQ` = 7;
  - `SEL_W` = 3;
  - the state enum `arb_state_t` {`IDLE`, `GRANT`}.
- Sub-module `rr_pick`: purely combinational, instantiated once. Inputs are `req` and `ptr`; outputs are `found` and a 3-bit `idx`, the first requester at or after `ptr` mod 7.
- The top holds the FSM, `ptr`, the output registers and the optional hold counter.

## Test plan
- Reset, then `req`=7'b0000000 for 5 cycles → `grant`=0, `grant_valid`=0, `mux_select`=0 throughout.
- `req`=7'b0010100 from `IDLE` with `ptr`=0 → next cycle `grant`=7'b0000100, `mux_select`=2. Drop `req[2]` → next cycle `grant`=7'b0010000, `mux_select`=4, with no idle cycle.
- Owner 6 releases while `req[0]` and `req[5]` are high → `ptr` wraps to 0 and `grant`=7'b0000001, `mux_select`=0.
- Hold `req`=7'b1111111 for 20 cycles, with each owner dropping its `req` for 1 cycle after holding 2 cycles → grants rotate 0,1,2,…,6,0 in order.
- With `HOLD_LIMIT_EN` and `HOLD_MAX`=15: owner 3 holds with `req[4]` high → grant moves to 4 at the edge where the counter hits 15. Without the macro, owner 3 keeps the grant for 40 cycles.
- Assert `reset` asynchronously mid-grant (owner 5) → outputs clear before the next clock edge. After release, `req`=7'b1100000 → `grant`=7'b0100000 (search restarts at 0).

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// mux_arb_pkg: shared constants, state type and small helpers for the
// round-robin arbiter that owns the select input of the 7-to-1 bit mux.
package mux_arb_pkg;

   localparam int N_REQ = 7;
   localparam int SEL_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Advance a requester index by one, wrapping 6 -> 0 so 7 is never produced.
   function automatic logic [SEL_W-1:0] wrapInc(input logic [SEL_W-1:0] idx);
      return (idx == SEL_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
   endfunction

   // One-hot grant vector for a requester index.
   function automatic logic [N_REQ-1:0] oneHot(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: request/grant bundle between the requesters and the
// arbiter. The requester side is the master, the arbiter is the slave.
interface mux_rr_arbiter_if;
   import mux_arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic             grant_valid;
   logic [SEL_W-1:0] mux_select;

   modport master (
      output req,
      input  grant,
      input  grant_valid,
      input  mux_select
   );

   modport slave (
      input  req,
      output grant,
      output grant_valid,
      output mux_select
   );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first asserted
// request at or after the pointer, scanning upward modulo 7.
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [SEL_W-1:0] i_ptr,
   output logic             o_found,
   output logic [SEL_W-1:0] o_idx
);

   localparam int POS_W = SEL_W + 1;

   logic [POS_W-1:0] w_pos;

   // Scan from the farthest offset back to the pointer so the closest hit wins.
   always_comb begin
      o_found = 1'b0;
      o_idx   = i_ptr;
      w_pos   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_pos = {1'b0, i_ptr} + POS_W'(k);
         if (w_pos >= POS_W'(N_REQ)) begin
            w_pos = w_pos - POS_W'(N_REQ);
         end
         if (i_req[w_pos[SEL_W-1:0]]) begin
            o_found = 1'b1;
            o_idx   = w_pos[SEL_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of the 7-to-1 mux select. A grant is held
// until the owner drops its request, then priority rotates past the owner.
// Optional feature macro HOLD_LIMIT_EN: bounds how long a grant may be held
// while other requesters wait (HOLD_MAX cycles), then preempts.
module mux_rr_arbiter #(
   parameter int N_REQ    = 7,
   parameter int HOLD_MAX = 15
) (
   input logic              clock,
   input logic              reset,
   mux_rr_arbiter_if.slave  bus
);
   import mux_arb_pkg::*;

   if (N_REQ != 7) begin : g_badNReq
      $error("mux_rr_arbiter only supports N_REQ = 7");
   end
   if (HOLD_MAX < 1) begin : g_badHoldMax
      $error("mux_rr_arbiter needs HOLD_MAX >= 1");
   end

   arb_state_t       r_state;
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] r_sel;
   logic [6:0]       r_grant;
   logic             r_valid;

   logic             w_preempt;
   logic             w_release;
   logic [SEL_W-1:0] w_nextPtr;
   logic [SEL_W-1:0] w_pickPtr;
   logic             w_found;
   logic [SEL_W-1:0] w_idx;
   logic             w_newGrant;

   // While granted, r_sel is the owner; a release or preemption rotates past it.
   assign w_release  = (r_state == GRANT) && (!bus.req[r_sel] || w_preempt);
   assign w_nextPtr  = wrapInc(r_sel);
   assign w_pickPtr  = (r_state == GRANT) ? w_nextPtr : r_ptr;
   assign w_newGrant = w_found && ((r_state == IDLE) || w_release);

   rr_pick u_pick (
      .i_req   (bus.req),
      .i_ptr   (w_pickPtr),
      .o_found (w_found),
      .o_idx   (w_idx)
   );

`ifdef HOLD_LIMIT_EN
   localparam int CNT_W = $clog2(HOLD_MAX + 1);

   logic [CNT_W-1:0] r_holdCnt;
   logic             w_othersWaiting;

   assign w_othersWaiting = |(bus.req & ~r_grant);
   assign w_preempt       = (r_holdCnt == CNT_W'(HOLD_MAX)) && w_othersWaiting;

   // Count cycles the current owner has held the mux; restart on every new grant and saturate.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_holdCnt <= '0;
      end else if (w_newGrant) begin
         r_holdCnt <= '0;
      end else if ((r_state == GRANT) && (r_holdCnt != CNT_W'(HOLD_MAX))) begin
         r_holdCnt <= r_holdCnt + 1'b1;
      end
   end
`else
   assign w_preempt = 1'b0;
`endif

   // Arbitration FSM with registered outputs; mux_select keeps its value when going idle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_sel   <= '0;
         r_grant <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_state <= GRANT;
                  r_sel   <= w_idx;
                  r_grant <= oneHot(w_idx);
                  r_valid <= 1'b1;
               end
            end
            GRANT: begin
               if (w_release) begin
                  r_ptr <= w_nextPtr;
                  if (w_found) begin
                     r_sel   <= w_idx;
                     r_grant <= oneHot(w_idx);
                  end else begin
                     r_state <= IDLE;
                     r_grant <= '0;
                     r_valid <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= '0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant       = r_grant;
   assign bus.grant_valid = r_valid;
   assign bus.mux_select  = r_sel;

endmodule
